// File: rtl/data_mem_ctrl.sv
// Wait-state data memory controller: single 24-bit RAM port, one request in flight,
// done WAIT_CYCLES+2 edges after acceptance; requests arriving while busy are dropped.
module data_mem_ctrl #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [23:0] data_addr,
    input  logic [23:0] wr_data,
    output logic [23:0] rd_data,
    output logic        mdr_load,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [23:0]            wdat_q;
    logic                   is_rd_q;
    logic                   err_q;
    logic [23:0]            rd_data_q;
    logic [23:0]            mem_q [0:(1<<ADDR_BITS)-1];

    logic accept;
    logic req_err;

    assign accept  = (state_q == S_IDLE) && (rd_req || wr_req);
    // Errors are resolved at acceptance so the access edge only has to honour a flag.
    assign req_err = (rd_req && wr_req) || ((data_addr >> ADDR_BITS) != 24'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (rd_req || wr_req) begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(WAIT_CYCLES);
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        err      = (state_q == S_DONE) && err_q;
        mdr_load = (state_q == S_DONE) && is_rd_q && !err_q;
        rd_data  = rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q    <= '0;
            wdat_q    <= 24'd0;
            is_rd_q   <= 1'b0;
            err_q     <= 1'b0;
            rd_data_q <= 24'd0;
        end else begin
            if (accept) begin
                addr_q  <= data_addr[ADDR_BITS-1:0];
                wdat_q  <= wr_data;
                is_rd_q <= rd_req;
                err_q   <= req_err;
            end
            if (state_q == S_ACCESS && is_rd_q && !err_q) begin
                rd_data_q <= mem_q[addr_q];
            end
        end
    end

    // RAM contents survive reset; reset only blocks a pending commit.
    always_ff @(posedge clk) begin
        if (!reset && state_q == S_ACCESS && !is_rd_q && !err_q) begin
            mem_q[addr_q] <= wdat_q;
        end
    end

endmodule
